// File: rtl/fft16_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fft16_seq_ctrl
// Brief    : Address/strobe sequencer for an in-place 16-point radix-2 DIF FFT.
// Revision : 1.0 - initial release
// ============================================================================
module fft16_seq_ctrl #(
   parameter int BF_LAT = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       rd_en,
   output logic [3:0] rd_addr_a,
   output logic [3:0] rd_addr_b,
   output logic [2:0] tw_addr,
   output logic       wr_en,
   output logic [3:0] wr_addr_a,
   output logic [3:0] wr_addr_b,
   output logic [1:0] stage
);

   localparam logic [3:0] c_drain_len = 4'(BF_LAT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] stage_q, stage_d;
   logic [2:0] k_q, k_d;
   logic [3:0] cnt_q, cnt_d;

   logic       rd_en_q;
   logic [3:0] rd_a_q, rd_b_q;
   logic [2:0] tw_q;

   logic       wen_sr_q [BF_LAT];
   logic [3:0] wa_sr_q  [BF_LAT];
   logic [3:0] wb_sr_q  [BF_LAT];

   // Top index: the group bits of k move up one position, the in-group bits stay.
   function automatic logic [3:0] f_addr_a(input logic [1:0] s, input logic [2:0] k);
      logic [3:0] kk;
      logic [3:0] mask;
      kk   = {1'b0, k};
      mask = (4'd8 >> s) - 4'd1;
      return ((kk & ~mask) << 1) | (kk & mask);
   endfunction

   function automatic logic [2:0] f_tw(input logic [1:0] s, input logic [2:0] k);
      logic [3:0] j;
      logic [3:0] t;
      j = {1'b0, k} & ((4'd8 >> s) - 4'd1);
      t = j << s;
      return t[2:0];
   endfunction

   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ISSUE;
               stage_d = 2'd0;
               k_d     = 3'd0;
            end
         end
         ISSUE: begin
            if (k_q == 3'd7) begin
               state_d = DRAIN;
               cnt_d   = c_drain_len;
               k_d     = 3'd0;
            end else begin
               k_d = k_q + 3'd1;
            end
         end
         DRAIN: begin
            if (cnt_q == 4'd1) begin
               if (stage_q == 2'd3) begin
                  state_d = FIN;
                  stage_d = 2'd0;
               end else begin
                  state_d = ISSUE;
                  stage_d = stage_q + 2'd1;
                  k_d     = 3'd0;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         stage_q <= 2'd0;
         k_q     <= 3'd0;
         cnt_q   <= 4'd0;
         rd_en_q <= 1'b0;
         rd_a_q  <= 4'd0;
         rd_b_q  <= 4'd0;
         tw_q    <= 3'd0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         // Issue outputs are computed from the next state so they align with ISSUE cycles.
         rd_en_q <= (state_d == ISSUE);
         if (state_d == ISSUE) begin
            rd_a_q <= f_addr_a(stage_d, k_d);
            rd_b_q <= f_addr_a(stage_d, k_d) | (4'd8 >> stage_d);
            tw_q   <= f_tw(stage_d, k_d);
         end else begin
            rd_a_q <= 4'd0;
            rd_b_q <= 4'd0;
            tw_q   <= 3'd0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BF_LAT; i++) begin
            wen_sr_q[i] <= 1'b0;
            wa_sr_q[i]  <= 4'd0;
            wb_sr_q[i]  <= 4'd0;
         end
      end else begin
         wen_sr_q[0] <= rd_en_q;
         wa_sr_q[0]  <= rd_a_q;
         wb_sr_q[0]  <= rd_b_q;
         for (int i = 1; i < BF_LAT; i++) begin
            wen_sr_q[i] <= wen_sr_q[i-1];
            wa_sr_q[i]  <= wa_sr_q[i-1];
            wb_sr_q[i]  <= wb_sr_q[i-1];
         end
      end
   end

   assign busy      = (state_q == ISSUE) || (state_q == DRAIN);
   assign done      = (state_q == FIN);
   assign rd_en     = rd_en_q;
   assign rd_addr_a = rd_a_q;
   assign rd_addr_b = rd_b_q;
   assign tw_addr   = tw_q;
   assign wr_en     = wen_sr_q[BF_LAT-1];
   assign wr_addr_a = wa_sr_q[BF_LAT-1];
   assign wr_addr_b = wb_sr_q[BF_LAT-1];
   assign stage     = stage_q;

endmodule
`default_nettype wire

// File: tb/tb_fft16_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft16_seq_ctrl
// Brief    : Self-checking bench; three sequencers (BF_LAT 1, 2, 5) vs a timing model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft16_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] start = 3'b000;
   logic [2:0] busy, done, rd_en, wr_en;
   logic [3:0] rd_a [3];
   logic [3:0] rd_b [3];
   logic [3:0] wr_a [3];
   logic [3:0] wr_b [3];
   logic [2:0] tw   [3];
   logic [1:0] stg  [3];

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int t0      [3] = '{-1, -1, -1};
   int lat_v   [3] = '{1, 2, 5};
   int rd_cnt  [3] = '{0, 0, 0};
   int wr_cnt  [3] = '{0, 0, 0};
   int done_at [3] = '{-1, -1, -1};

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      fft16_seq_ctrl #(.BF_LAT(gi == 0 ? 1 : (gi == 1 ? 2 : 5))) u_dut (
         .clk       (clk),
         .rst       (rst),
         .start     (start[gi]),
         .busy      (busy[gi]),
         .done      (done[gi]),
         .rd_en     (rd_en[gi]),
         .rd_addr_a (rd_a[gi]),
         .rd_addr_b (rd_b[gi]),
         .tw_addr   (tw[gi]),
         .wr_en     (wr_en[gi]),
         .wr_addr_a (wr_a[gi]),
         .wr_addr_b (wr_b[gi]),
         .stage     (stg[gi])
      );
   end

   // {valid, a, b, tw} of the butterfly issued n cycles after start was sampled.
   function automatic logic [11:0] issue_at(int L, int n);
      int m, s, k, span, j, g, a;
      m = n - 1;
      if (m < 0) return 12'd0;
      s = m / (8 + L);
      k = m % (8 + L);
      if (s > 3 || k > 7) return 12'd0;
      span = 8 >> s;
      j    = k % span;
      g    = k / span;
      a    = 2 * span * g + j;
      return {1'b1, 4'(a), 4'(a + span), 3'((j << s) % 8)};
   endfunction

   function automatic logic [24:0] exp_vec(int i);
      int L, n, st;
      logic [11:0] iv, wv;
      logic bz, dn;
      if (t0[i] < 0) return 25'd0;
      L  = lat_v[i];
      n  = cyc - t0[i];
      iv = issue_at(L, n);
      wv = issue_at(L, n - L);
      bz = (n >= 1) && (n <= 4 * (8 + L));
      dn = (n == 4 * (8 + L) + 1);
      st = bz ? (n - 1) / (8 + L) : 0;
      return {bz, dn, iv, wv[11:3], 2'(st)};
   endfunction

   function automatic logic [24:0] act_vec(int i);
      return {busy[i], done[i], rd_en[i], rd_a[i], rd_b[i], tw[i],
              wr_en[i], wr_a[i], wr_b[i], stg[i]};
   endfunction

   task automatic chk(input string tag, input int got, input int expv);
      vectors++;
      assert (got === expv) else begin
         miscompares++;
         $error("FAIL %s: got %0d expected %0d", tag, got, expv);
      end
   endtask

   task automatic check_all();
      logic [24:0] e, a;
      for (int i = 0; i < 3; i++) begin
         e = exp_vec(i);
         a = act_vec(i);
         vectors++;
         assert (a === e) else begin
            miscompares++;
            $error("FAIL outputs lat%0d cyc=%0d: got %h expected %h", lat_v[i], cyc, a, e);
         end
         if (rd_en[i] === 1'b1) rd_cnt[i]++;
         if (wr_en[i] === 1'b1) wr_cnt[i]++;
         if (done[i] === 1'b1 && done_at[i] < 0) done_at[i] = cyc;
      end
   endtask

   // Model accepts start only when idle: no run yet, or the run's FIN cycle is past.
   task automatic step(input logic [2:0] st);
      for (int i = 0; i < 3; i++)
         if (!rst && st[i] && (t0[i] < 0 || cyc - t0[i] >= 4 * (8 + lat_v[i]) + 2))
            t0[i] = cyc;
      start = st;
      @(posedge clk);
      cyc++;
      #1;
      check_all();
   endtask

   task automatic clear_stats();
      for (int i = 0; i < 3; i++) begin
         rd_cnt[i]  = 0;
         wr_cnt[i]  = 0;
         done_at[i] = -1;
      end
   endtask

   int base, rel, first_rd2;
   int ck_n [5] = '{4, 16, 22, 27, 38};
   int ck_a [5] = '{3, 9, 1, 12, 14};
   int ck_b [5] = '{11, 13, 3, 14, 15};
   int ck_t [5] = '{3, 2, 4, 0, 0};

   initial begin
      // Reset state
      step(3'b000);
      step(3'b111);
      rst = 1'b0;

      // Single run with ignored starts at 5, 20, 41 and a restart at 42
      clear_stats();
      base      = cyc;
      first_rd2 = -1;
      for (int r = 0; r < 120; r++) begin
         step((r == 0 || r == 5 || r == 20 || r == 41 || r == 42) ? 3'b111 : 3'b000);
         rel = cyc - base;
         for (int t = 0; t < 5; t++) begin
            if (rel == ck_n[t]) begin
               chk("addr_a", int'(rd_a[1]), ck_a[t]);
               chk("addr_b", int'(rd_b[1]), ck_b[t]);
               chk("tw",     int'(tw[1]),   ck_t[t]);
            end
         end
         if (rel == 41) begin
            chk("rd_count", rd_cnt[1], 32);
            chk("wr_count", wr_cnt[1], 32);
         end
         if (rel > 41 && rd_en[1] === 1'b1 && first_rd2 < 0) first_rd2 = rel;
      end
      chk("done_cycle_lat2", done_at[1] - base, 41);
      chk("done_cycle_lat5", done_at[2] - base, 53);
      chk("done_cycle_lat1", done_at[0] - base, 37);
      chk("restart_first_issue", first_rd2, 43);

      // Asynchronous reset during ISSUE of stage 1
      step(3'b111);
      for (int r = 0; r < 13; r++) step(3'b000);
      #2;
      rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         t0[i] = -1;
         chk("async_reset_outputs", int'(act_vec(i)), 0);
      end
      step(3'b000);
      rst = 1'b0;
      clear_stats();
      for (int r = 0; r < 20; r++) step(3'b000);
      chk("no_wr_after_reset", wr_cnt[0] + wr_cnt[1] + wr_cnt[2], 0);

      // Full pass after reset
      clear_stats();
      step(3'b111);
      for (int r = 0; r < 60; r++) step(3'b000);
      for (int i = 0; i < 3; i++) begin
         chk("pass_rd_count", rd_cnt[i], 32);
         chk("pass_wr_count", wr_cnt[i], 32);
      end

      // Randomized start pulses
      for (int r = 0; r < 1500; r++)
         step({($urandom_range(0, 24) == 0), ($urandom_range(0, 24) == 0),
               ($urandom_range(0, 24) == 0)});
      for (int r = 0; r < 60; r++) step(3'b000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
